seq_shifter: RTL

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter_pkg.sv | 30 +++
 rtl/seq_shifter_shift_step.sv | 38 +++
 rtl/seq_shifter.sv | 103 ++++++++++
 3 files changed

// File: rtl/seq_shifter_pkg.sv
// Shared op-code constants, FSM state type and op decode for seq_shifter.
// Rotate decode is present only when SEQ_SHIFTER_ROTATE_EN is defined.
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [2:0] OpShl  = 3'b000;
    localparam logic [2:0] OpShr  = 3'b001;
    localparam logic [2:0] OpShra = 3'b010;
    localparam logic [2:0] OpRol  = 3'b011;
    localparam logic [2:0] OpRor  = 3'b100;

    // True for ops that need RUN cycles; everything else is pass-through.
    function automatic logic op_uses_shift(input logic [2:0] op);
        logic r;
        case (op)
            OpShl, OpShr, OpShra: r = 1'b1;
`ifdef SEQ_SHIFTER_ROTATE_EN
            OpRol, OpRor:         r = 1'b1;
`endif
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// shift_step: combinational shift/rotate of one word by k bits (k <= STEP).
// Rotate paths exist only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned KW    = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_op,
    input  logic [KW-1:0]    i_k,
    output logic [WIDTH-1:0] o_data
);

`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;

    // k may equal WIDTH, in which case the shifted-out half is the whole word.
    assign w_rol = (i_data << i_k) | (i_data >> (WIDTH - 32'(i_k)));
    assign w_ror = (i_data >> i_k) | (i_data << (WIDTH - 32'(i_k)));
`endif

    always_comb begin
        o_data = i_data;
        case (i_op)
            OpShl:  o_data = i_data << i_k;
            OpShr:  o_data = i_data >> i_k;
            OpShra: o_data = $unsigned($signed(i_data) >>> i_k);
`ifdef SEQ_SHIFTER_ROTATE_EN
            OpRol:  o_data = w_rol;
            OpRor:  o_data = w_ror;
`endif
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts up to STEP bits per cycle until the count is exhausted.
// Define SEQ_SHIFTER_ROTATE_EN to enable ROL/ROR; otherwise those codes pass through.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned KW = $clog2(STEP + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_nxt;
    logic [AMT_W-1:0] r_rem;
    logic [AMT_W-1:0] w_rem_nxt;
    logic [2:0]       r_op;
    logic [2:0]       w_op_nxt;
    logic [KW-1:0]    w_k;
    logic [WIDTH-1:0] w_stepped;

    // Bits to shift this cycle: min(STEP, remaining).
    assign w_k = (32'(r_rem) < STEP) ? KW'(r_rem) : KW'(STEP);

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_shift_step (
        .i_data (r_work),
        .i_op   (r_op),
        .i_k    (w_k),
        .o_data (w_stepped)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        w_dout_nxt  = r_dout;

        case (r_state)
            StRun: begin
                w_work_nxt = w_stepped;
                w_rem_nxt  = r_rem - AMT_W'(w_k);
                if (r_rem == AMT_W'(w_k)) begin
                    w_state_nxt = StDone;
                    w_dout_nxt  = w_stepped;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // Accept in IDLE or DONE; a start while running is dropped entirely.
        if (start && (r_state != StRun)) begin
            w_op_nxt   = op;
            w_work_nxt = din;
            if (op_uses_shift(op) && (amount != '0)) begin
                w_state_nxt = StRun;
                w_rem_nxt   = amount;
            end else begin
                w_state_nxt = StDone;
                w_rem_nxt   = '0;
                w_dout_nxt  = din;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= StIdle;
            r_work  <= '0;
            r_dout  <= '0;
            r_rem   <= '0;
            r_op    <= OpShl;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_dout  <= w_dout_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign busy = (r_state == StRun);
    assign done = (r_state == StDone);
    assign dout = r_dout;

endmodule
